// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared defaults, FSM state type and index-width helper for the tile assembler
package tile_pkg;

  localparam int TILE_DATA_W = 8;
  localparam int TILE_ROWS   = 8;
  localparam int TILE_COLS   = 16;
  localparam int TILE_DEPTH  = TILE_ROWS * TILE_COLS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } tile_state_e;

  // Keeps index vectors at least one bit wide for degenerate 1-row/1-col tiles.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tile_wr_ptr.sv
// rtl/tile_wr_ptr.sv - row/col write pointer for the tile buffer with wrap and last-element detect
module tile_wr_ptr
  import tile_pkg::*;
#(
  parameter  int ROWS  = TILE_ROWS,
  parameter  int COLS  = TILE_COLS,
  parameter  int DEPTH = ROWS * COLS,
  localparam int ROW_W = idx_w(ROWS),
  localparam int COL_W = idx_w(COLS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  input  logic             clr_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             last_o
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  assign last_o = ((int'(row_q) * COLS) + int'(col_q)) == (DEPTH - 1);
  assign row_o  = row_q;
  assign col_o  = col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (adv_i) begin
      if (last_o) begin
        row_d = '0;
        col_d = '0;
      end else if (col_q == COL_W'(COLS - 1)) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/tile_assembler.sv
// rtl/tile_assembler.sv - packs a byte stream into a ROWSxCOLS tile held until the consumer takes it
// Optional running byte checksum output tile_sum when TILE_ASSEMBLER_CHECKSUM_EN is defined.
module tile_assembler
  import tile_pkg::*;
#(
  parameter int DATA_W = TILE_DATA_W,
  parameter int ROWS   = TILE_ROWS,
  parameter int COLS   = TILE_COLS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] tile_data [0:ROWS-1][0:COLS-1],
  output logic [15:0]       tile_tag,
  output logic              tile_valid,
  input  logic              tile_ready,
  output logic              tile_short
`ifdef TILE_ASSEMBLER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] tile_sum
`endif
);

  localparam int DEPTH = ROWS * COLS;
  localparam int ROW_W = idx_w(ROWS);
  localparam int COL_W = idx_w(COLS);

  tile_state_e      state_q;
  logic             in_ready_q;
  logic             valid_q;
  logic             short_q;
  logic [15:0]      tag_q;
  logic [DATA_W-1:0] data_q [0:ROWS-1][0:COLS-1];

  logic             accept;
  logic             handoff;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;
  logic             wr_last;

  assign accept  = in_valid && in_ready_q;
  assign handoff = valid_q && tile_ready;

  tile_wr_ptr #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .DEPTH (DEPTH)
  ) u_wr_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .adv_i  (accept),
    .clr_i  (handoff),
    .row_o  (wr_row),
    .col_o  (wr_col),
    .last_o (wr_last)
  );

`ifdef TILE_ASSEMBLER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk) begin
    if (!rst_n || handoff) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + in_data;
    end
  end

  assign tile_sum = sum_q;
`endif

  // A full tile with in_last on its final byte is still a complete tile, hence short = ~wr_last.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b1;
      valid_q    <= 1'b0;
      short_q    <= 1'b0;
      tag_q      <= '0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          data_q[r][c] <= '0;
        end
      end
    end else begin
      case (state_q)
        IDLE, FILL: begin
          if (accept) begin
            data_q[wr_row][wr_col] <= in_data;
            if (in_last || wr_last) begin
              state_q    <= FULL;
              in_ready_q <= 1'b0;
              valid_q    <= 1'b1;
              short_q    <= ~wr_last;
            end else begin
              state_q <= FILL;
            end
          end
        end
        FULL: begin
          if (tile_ready) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            valid_q    <= 1'b0;
            short_q    <= 1'b0;
            tag_q      <= tag_q + 16'd1;
            for (int r = 0; r < ROWS; r++) begin
              for (int c = 0; c < COLS; c++) begin
                data_q[r][c] <= '0;
              end
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
          valid_q    <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign tile_valid = valid_q;
  assign tile_short = short_q;
  assign tile_tag   = tag_q;
  assign tile_data  = data_q;

endmodule
